// File: rtl/sw_array_ctrl.sv
// ============================================================================
// Module  : sw_array_ctrl
// Brief   : Sequencer for a linear Smith-Waterman PE array. Loads the query,
//           streams one target per job into PE0 and returns the unbiased
//           score and target length over a valid/ready result port.
//           Optional macro SW_CTRL_PERF_CNT_EN adds job/cell counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_array_ctrl #(
    parameter int N_PE          = 8,
    parameter int SCORE_WIDTH   = 12,
    parameter int TLEN_WIDTH    = 10,
    parameter int DRAIN_TIMEOUT = 2*N_PE+8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q_wr_en,
    input  logic [1:0]             q_wr_data,
    input  logic                   q_clear,
    output logic                   q_full,
    output logic [2*N_PE-1:0]      query_bus,
    input  logic                   t_valid,
    input  logic [1:0]             t_data,
    input  logic                   t_last,
    output logic                   t_ready,
    output logic                   arr_en,
    output logic [1:0]             arr_data,
    input  logic                   arr_vld,
    input  logic [SCORE_WIDTH-1:0] arr_high,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SCORE_WIDTH-2:0] res_score,
    output logic [TLEN_WIDTH-1:0]  res_len,
    output logic [1:0]             res_err,
`ifdef SW_CTRL_PERF_CNT_EN
    output logic [15:0]            perf_jobs,
    output logic [31:0]            perf_cells,
`endif
    output logic                   busy
);

    localparam int QW = $clog2(N_PE+1);
    localparam int TW = $clog2(DRAIN_TIMEOUT+1);
    localparam logic [QW-1:0]          c_QFULL   = QW'(N_PE);
    localparam logic [TW-1:0]          c_TMAX    = TW'(DRAIN_TIMEOUT-1);
    localparam logic [TLEN_WIDTH-1:0]  c_LEN_MAX = {TLEN_WIDTH{1'b1}};
    localparam logic [SCORE_WIDTH-1:0] c_ZERO    = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [QW-1:0]            qcnt_q, qcnt_d;
    logic [2*N_PE-1:0]        query_q, query_d;
    logic                     arr_en_q, arr_en_d;
    logic [1:0]               arr_data_q, arr_data_d;
    logic [TLEN_WIDTH-1:0]    len_q, len_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;
    logic [SCORE_WIDTH-2:0]   score_q, score_d;
    logic [1:0]               err_q, err_d;
    logic                     res_valid_q, res_valid_d;

    logic                     w_q_full;
    logic                     w_t_ready;
    logic                     w_accept;
    logic                     w_handshake;
    logic [SCORE_WIDTH-1:0]   w_diff;
    logic                     w_below;

    assign w_q_full    = (qcnt_q == c_QFULL);
    assign w_t_ready   = w_q_full & ((state_q == S_IDLE) | (state_q == S_STREAM));
    assign w_accept    = t_valid & w_t_ready;
    assign w_handshake = (state_q == S_RESULT) & res_valid_q & res_ready;
    // A borrow out of the bias subtraction means the high score sits below ZERO.
    assign w_diff      = arr_high - c_ZERO;
    assign w_below     = w_diff[SCORE_WIDTH-1];

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        query_d     = query_q;
        arr_en_d    = 1'b0;
        arr_data_d  = arr_data_q;
        len_d       = len_q;
        tcnt_d      = '0;
        score_d     = score_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;

        case (state_q)
            S_IDLE: begin
                if (q_clear) begin
                    qcnt_d  = '0;
                    query_d = '0;
                end else if (q_wr_en && !w_q_full) begin
                    for (int i = 0; i < N_PE; i++) begin
                        if (qcnt_q == QW'(i)) begin
                            query_d[2*i +: 2] = q_wr_data;
                        end
                    end
                    qcnt_d = qcnt_q + 1'b1;
                end
                if (w_accept) begin
                    arr_en_d   = 1'b1;
                    arr_data_d = t_data;
                    len_d      = TLEN_WIDTH'(1);
                    err_d      = 2'b00;
                    state_d    = t_last ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                if (t_valid) begin
                    arr_en_d   = 1'b1;
                    arr_data_d = t_data;
                    if (len_q != c_LEN_MAX) begin
                        len_d = len_q + 1'b1;
                    end
                    if (t_last) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    // The PEs need a contiguous enable burst; a bubble ends the job.
                    err_d[0] = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (arr_vld) begin
                    score_d     = w_below ? '0 : w_diff[SCORE_WIDTH-2:0];
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else if (tcnt_q == c_TMAX) begin
                    err_d[1]    = 1'b1;
                    score_d     = '0;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (w_handshake) begin
                    res_valid_d = 1'b0;
                    err_d       = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            query_q     <= '0;
            arr_en_q    <= 1'b0;
            arr_data_q  <= 2'b00;
            len_q       <= '0;
            tcnt_q      <= '0;
            score_q     <= '0;
            err_q       <= 2'b00;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            query_q     <= query_d;
            arr_en_q    <= arr_en_d;
            arr_data_q  <= arr_data_d;
            len_q       <= len_d;
            tcnt_q      <= tcnt_d;
            score_q     <= score_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef SW_CTRL_PERF_CNT_EN
    logic [15:0] perf_jobs_q, perf_jobs_d;
    logic [31:0] perf_cells_q, perf_cells_d;

    always_comb begin
        perf_jobs_d  = perf_jobs_q + (w_handshake ? 16'd1 : 16'd0);
        perf_cells_d = perf_cells_q + (arr_en_q ? 32'(N_PE) : 32'd0);
        if ((state_q == S_IDLE) && q_clear) begin
            perf_jobs_d  = '0;
            perf_cells_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_jobs_q  <= '0;
            perf_cells_q <= '0;
        end else begin
            perf_jobs_q  <= perf_jobs_d;
            perf_cells_q <= perf_cells_d;
        end
    end

    assign perf_jobs  = perf_jobs_q;
    assign perf_cells = perf_cells_q;
`endif

    assign q_full    = w_q_full;
    assign query_bus = query_q;
    assign t_ready   = w_t_ready;
    assign arr_en    = arr_en_q;
    assign arr_data  = arr_data_q;
    assign res_valid = res_valid_q;
    assign res_score = score_q;
    assign res_len   = len_q;
    assign res_err   = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sw_array_ctrl.sv
// ============================================================================
// Module  : tb_sw_array_ctrl
// Brief   : Self-checking bench for sw_array_ctrl (N_PE=4) with a stubbed
//           PE chain and a small affine-gap Smith-Waterman reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_array_ctrl;

    localparam int NP  = 4;
    localparam int SW  = 12;
    localparam int TLW = 10;
    localparam int DT  = 2*NP+8;

    logic           clk = 1'b0;
    logic           rst;
    logic           q_wr_en, q_clear;
    logic [1:0]     q_wr_data;
    logic           q_full;
    logic [2*NP-1:0] query_bus;
    logic           t_valid, t_last, t_ready;
    logic [1:0]     t_data;
    logic           arr_en, arr_vld;
    logic [1:0]     arr_data;
    logic [SW-1:0]  arr_high;
    logic           res_valid, res_ready;
    logic [SW-2:0]  res_score;
    logic [TLW-1:0] res_len;
    logic [1:0]     res_err;
    logic           busy;
`ifdef SW_CTRL_PERF_CNT_EN
    logic [15:0]    perf_jobs;
    logic [31:0]    perf_cells;
`endif

    sw_array_ctrl #(.N_PE(NP), .SCORE_WIDTH(SW), .TLEN_WIDTH(TLW), .DRAIN_TIMEOUT(DT)) dut (
        .clk(clk), .rst(rst),
        .q_wr_en(q_wr_en), .q_wr_data(q_wr_data), .q_clear(q_clear),
        .q_full(q_full), .query_bus(query_bus),
        .t_valid(t_valid), .t_data(t_data), .t_last(t_last), .t_ready(t_ready),
        .arr_en(arr_en), .arr_data(arr_data), .arr_vld(arr_vld), .arr_high(arr_high),
        .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score),
        .res_len(res_len), .res_err(res_err),
`ifdef SW_CTRL_PERF_CNT_EN
        .perf_jobs(perf_jobs), .perf_cells(perf_cells),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int en_cycles = 0;
    always @(posedge clk) if (arr_en) en_cycles <= en_cycles + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] tx  [16];
    logic [1:0] cap [16];

    typedef struct {
        logic       wr;
        logic [1:0] d;
        logic       clr;
        logic       exp_full;
        logic [7:0] exp_qbus;
    } qvec_t;

    qvec_t vec [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Streams n beats from tx[]; ends two negedges after the final acceptance.
    task automatic send_beats(input int n, input logic last_on_final);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("arr_en_before_burst", arr_en, 0);
            end else begin
                chk("arr_en_in_burst", arr_en, 1);
                chk("arr_data_in_burst", arr_data, tx[i-1]);
                cap[i-1] = arr_data;
            end
            chk("t_ready_streaming", t_ready, 1);
            t_valid = 1'b1;
            t_data  = tx[i];
            t_last  = last_on_final && (i == n-1);
        end
        @(negedge clk);
        t_valid = 1'b0;
        t_last  = 1'b0;
        chk("arr_en_last_beat", arr_en, 1);
        chk("arr_data_last_beat", arr_data, tx[n-1]);
        cap[n-1] = arr_data;
        @(negedge clk);
        chk("arr_en_drop", arr_en, 0);
        chk("t_ready_drain", t_ready, 0);
        chk("busy_drain", busy, 1);
    endtask

    task automatic stub_vld(input logic [SW-1:0] high);
        arr_vld  = 1'b1;
        arr_high = high;
        @(negedge clk);
        arr_vld  = 1'b0;
    endtask

    task automatic take_result(input string nm, input int sc, input int ln, input int er);
        chk({nm, "_valid"}, res_valid, 1);
        chk({nm, "_score"}, res_score, 64'(sc));
        chk({nm, "_len"}, res_len, 64'(ln));
        chk({nm, "_err"}, res_err, 64'(er));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({nm, "_valid_clr"}, res_valid, 0);
        chk({nm, "_err_clr"}, res_err, 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Affine-gap local alignment: match +2, mismatch -1, gap open -2, extend -1.
    function automatic int sw_score(input logic [1:0] tg[16], input int n, input logic [7:0] qb);
        int h [17][NP+1];
        int e [17][NP+1];
        int f [17][NP+1];
        int best = 0;
        logic [1:0] qbase;
        for (int i = 0; i <= 16; i++)
            for (int j = 0; j <= NP; j++) begin
                h[i][j] = 0; e[i][j] = -100; f[i][j] = -100;
            end
        for (int i = 1; i <= n; i++)
            for (int j = 1; j <= NP; j++) begin
                qbase   = qb[2*(j-1) +: 2];
                e[i][j] = imax(h[i][j-1] - 2, e[i][j-1] - 1);
                f[i][j] = imax(h[i-1][j] - 2, f[i-1][j] - 1);
                h[i][j] = imax(0, h[i-1][j-1] + ((tg[i-1] == qbase) ? 2 : -1));
                h[i][j] = imax(h[i][j], imax(e[i][j], f[i][j]));
                best    = imax(best, h[i][j]);
            end
        return best;
    endfunction

    initial begin
        int cnt;
        int en0;
        int sc;

        //          wr    d      clr   full  qbus
        vec[0]  = '{1'b1, 2'b00, 1'b0, 1'b0, 8'h00};
        vec[1]  = '{1'b1, 2'b01, 1'b0, 1'b0, 8'h04};
        vec[2]  = '{1'b1, 2'b10, 1'b0, 1'b0, 8'h24};
        vec[3]  = '{1'b1, 2'b11, 1'b0, 1'b1, 8'hE4};
        vec[4]  = '{1'b1, 2'b00, 1'b0, 1'b1, 8'hE4};
        vec[5]  = '{1'b1, 2'b01, 1'b1, 1'b0, 8'h00};
        vec[6]  = '{1'b1, 2'b11, 1'b0, 1'b0, 8'h03};
        vec[7]  = '{1'b0, 2'b00, 1'b1, 1'b0, 8'h00};
        vec[8]  = '{1'b1, 2'b00, 1'b0, 1'b0, 8'h00};
        vec[9]  = '{1'b1, 2'b01, 1'b0, 1'b0, 8'h04};
        vec[10] = '{1'b1, 2'b10, 1'b0, 1'b0, 8'h24};
        vec[11] = '{1'b1, 2'b11, 1'b0, 1'b1, 8'hE4};

        rst = 1'b0; q_wr_en = 0; q_wr_data = 0; q_clear = 0;
        t_valid = 0; t_data = 0; t_last = 0;
        arr_vld = 0; arr_high = 0; res_ready = 0;
        for (int i = 0; i < 16; i++) begin tx[i] = 2'b00; cap[i] = 2'b00; end

        repeat (3) @(negedge clk);
        chk("rst_arr_en", arr_en, 0);
        chk("rst_arr_data", arr_data, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_score", res_score, 0);
        chk("rst_res_len", res_len, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_q_full", q_full, 0);
        chk("rst_query_bus", query_bus, 0);
        chk("rst_t_ready", t_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;

        // Query load table: slot order, write-while-full, clear priority.
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            q_wr_en   = vec[v].wr;
            q_wr_data = vec[v].d;
            q_clear   = vec[v].clr;
            @(posedge clk);
            #1;
            q_wr_en = 1'b0;
            q_clear = 1'b0;
            chk($sformatf("qvec%0d_full", v), q_full, vec[v].exp_full);
            chk($sformatf("qvec%0d_qbus", v), query_bus, vec[v].exp_qbus);
        end

        // Job 1: six back-to-back beats, bias 2048+7.
        tx[0] = 2'b00; tx[1] = 2'b01; tx[2] = 2'b10; tx[3] = 2'b11; tx[4] = 2'b00; tx[5] = 2'b01;
        @(negedge clk);
        en0 = en_cycles;
        send_beats(6, 1'b1);
        chk("job1_en_cycles", 64'(en_cycles - en0), 6);
        stub_vld(12'd2055);
        // A late arr_vld while holding the result must not disturb it.
        stub_vld(12'd2060);
        chk("vld_outside_drain", res_score, 7);
        take_result("job1", 7, 6, 0);

        // Bubble after three beats.
        tx[0] = 2'b11; tx[1] = 2'b10; tx[2] = 2'b01;
        send_beats(3, 1'b0);
        stub_vld(12'd2050);
        take_result("bubble", 2, 3, 1);

        // Single-beat job with no arr_vld: timeout path.
        tx[0] = 2'b10;
        send_beats(1, 1'b1);
        chk("timeout_not_early", res_valid, 0);
        cnt = 1;
        while (!res_valid && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("timeout_cycles", 64'(cnt), DT);
        @(negedge clk);
        take_result("timeout", 0, 1, 2);

        // Two consecutive 4-beat jobs, query retained, t_ready low until handshake.
        tx[0] = 2'b00; tx[1] = 2'b00; tx[2] = 2'b11; tx[3] = 2'b01;
        send_beats(4, 1'b1);
        stub_vld(12'd4095);
        chk("jobA_t_ready_result", t_ready, 0);
        repeat (2) @(negedge clk);
        chk("jobA_t_ready_hold", t_ready, 0);
        chk("jobA_valid_hold", res_valid, 1);
        take_result("jobA", 2047, 4, 0);
        chk("jobA_query_kept", query_bus, 8'hE4);
        tx[0] = 2'b10; tx[1] = 2'b11; tx[2] = 2'b10; tx[3] = 2'b00;
        send_beats(4, 1'b1);
        stub_vld(12'd2047);
        take_result("jobB", 0, 4, 0);
        chk("jobB_query_kept", query_bus, 8'hE4);

        // Reset mid-stream.
        @(negedge clk);
        t_valid = 1'b1; t_data = 2'b01; t_last = 1'b0;
        @(negedge clk);
        t_data = 2'b10;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_arr_en", arr_en, 0);
        chk("mid_rst_t_ready", t_ready, 0);
        chk("mid_rst_q_full", q_full, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_query", query_bus, 0);
        rst = 1'b1;
        t_valid = 1'b0;

        // Real-chain scenario: query ACGT against target ACGT via the reference model.
        tx[0] = 2'b00; tx[1] = 2'b11; tx[2] = 2'b01; tx[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            q_wr_en   = 1'b1;
            q_wr_data = tx[i];
        end
        @(negedge clk);
        q_wr_en = 1'b0;
        chk("acgt_qbus", query_bus, 8'h9C);
        chk("acgt_full", q_full, 1);
        send_beats(4, 1'b1);
        sc = sw_score(cap, 4, 8'h9C);
        stub_vld(12'(2048 + sc));
        take_result("acgt", 8, 4, 0);
`ifdef SW_CTRL_PERF_CNT_EN
        chk("perf_jobs", perf_jobs, 1);
        chk("perf_cells", perf_cells, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
